// File: rtl/control_pkg.sv
// Shared encodings for the CPU main decoder: opcodes, control-bit positions
// inside the 14-bit bundle, and the bundle's packed layout.
package control_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ANDI  = 4'h2;
    localparam logic [3:0] OP_ORI   = 4'h3;
    localparam logic [3:0] OP_BLT   = 4'h4;
    localparam logic [3:0] OP_BGT   = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_LW    = 4'h8;
    localparam logic [3:0] OP_SW    = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int unsigned BIT_REGDST   = 13;
    localparam int unsigned BIT_BRANCH   = 12;
    localparam int unsigned BIT_MEMREAD  = 11;
    localparam int unsigned BIT_MEMWRITE = 10;
    localparam int unsigned BIT_ALUSRC   = 9;
    localparam int unsigned BIT_REGWRITE = 8;

    localparam logic [3:0] FUNCT_RSVD_E = 4'hE;
    localparam logic [3:0] FUNCT_RSVD_F = 4'hF;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [3:0] opcode;
        logic [3:0] funct_code;
    } ctrl_bundle_t;

    function automatic logic is_reserved_funct(input logic [3:0] funct);
        return (funct == FUNCT_RSVD_E) || (funct == FUNCT_RSVD_F);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: 8-bit instruction to 14-bit control bundle.
module control_decode
    import control_pkg::*;
(
    input  logic [7:0]  instruction_i,
    output logic [13:0] bundle_o
);

    logic [3:0] opcode;
    logic [3:0] funct;

    assign opcode = instruction_i[7:4];
    assign funct  = instruction_i[3:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        bundle_o      = '0;
        bundle_o[7:4] = opcode;
        bundle_o[3:0] = funct;
        // Reserved and unknown opcodes fall through to default: all control bits 0.
        unique case (opcode)
            OP_RTYPE: begin
                if (!is_reserved_funct(funct)) begin
                    bundle_o[BIT_REGDST]   = 1'b1;
                    bundle_o[BIT_REGWRITE] = 1'b1;
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                bundle_o[BIT_ALUSRC]   = 1'b1;
                bundle_o[BIT_REGWRITE] = 1'b1;
            end
            // JMP shares the branch encoding; the branch unit tells it apart by opcode.
            OP_BLT, OP_BGT, OP_BEQ, OP_JMP: begin
                bundle_o[BIT_BRANCH] = 1'b1;
            end
            OP_LW: begin
                bundle_o[BIT_MEMREAD]  = 1'b1;
                bundle_o[BIT_ALUSRC]   = 1'b1;
                bundle_o[BIT_REGWRITE] = 1'b1;
            end
            OP_SW: begin
                bundle_o[BIT_MEMWRITE] = 1'b1;
                bundle_o[BIT_ALUSRC]   = 1'b1;
            end
            OP_HALT: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/control.sv
// Main decoder top: combinational decode followed by a single async-reset
// output register, so the bundle changes only on rising clock edges.
module control
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  instruction,
    output logic [13:0] signals
);

    ctrl_bundle_t signals_d;
    ctrl_bundle_t signals_q;

    control_decode u_decode (
        .instruction_i (instruction),
        .bundle_o      (signals_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            signals_q <= '0;
        end else begin
            signals_q <= signals_d;
        end
    end

    assign signals = signals_q;

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the control decoder.
module tb_control;

    logic        clk;
    logic        rst_n;
    logic [7:0]  instruction;
    logic [13:0] signals;

    int tests;
    int fails;

    control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .signals     (signals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: control bits {regdst,branch,memread,memwrite,alusrc,regwrite}.
    function automatic logic [13:0] ref_decode(input logic [7:0] ins);
        logic [5:0] c;
        case (ins[7:4])
            4'h0:                c = (ins[3:0] >= 4'hE) ? 6'b000000 : 6'b100001;
            4'h1, 4'h2, 4'h3:    c = 6'b000011;
            4'h4, 4'h5, 4'h6,
            4'h7:                c = 6'b010000;
            4'h8:                c = 6'b001011;
            4'hB:                c = 6'b000110;
            default:             c = 6'b000000;
        endcase
        return {c, ins};
    endfunction

    task automatic apply(input logic [7:0] ins);
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        instruction = 8'h80;
        #1;
        tests++;
        if (signals !== 14'h0000) begin
            fails++; $display("FAIL reset_initial: got %h want 0000", signals);
        end
        @(posedge clk); #1;
        tests++;
        if (signals !== 14'h0000) begin
            fails++; $display("FAIL reset_hold: got %h want 0000", signals);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (signals !== 14'h0000) begin
            fails++; $display("FAIL reset_release_no_edge: got %h want 0000", signals);
        end
        @(posedge clk); #1;
        tests++;
        if (signals !== 14'h0B80) begin
            fails++; $display("FAIL reset_first_edge: got %h want 0B80", signals);
        end
        // Mid-stream reset between edges discards the pending decode.
        @(negedge clk);
        instruction = 8'h0D;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (signals !== 14'h0000) begin
            fails++; $display("FAIL reset_async_assert: got %h want 0000", signals);
        end
        @(posedge clk); #1;
        tests++;
        if (signals !== 14'h0000) begin
            fails++; $display("FAIL reset_discard_pending: got %h want 0000", signals);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (signals !== 14'h210D) begin
            fails++; $display("FAIL reset_resume: got %h want 210D", signals);
        end
    endtask

    task automatic test_rtype;
        logic [7:0]  ins [4] = '{8'h0D, 8'h01, 8'h08, 8'h0E};
        logic [13:0] exp [4] = '{14'h210D, 14'h2101, 14'h2108, 14'h000E};
        logic [13:0] prev;
        for (int i = 0; i < 4; i++) begin
            prev = signals;
            @(negedge clk);
            instruction = ins[i];
            #1;
            tests++;
            if (signals !== prev) begin
                fails++; $display("FAIL rtype_early_%h: got %h want %h", ins[i], signals, prev);
            end
            @(posedge clk); #1;
            tests++;
            if (signals !== exp[i]) begin
                fails++; $display("FAIL rtype_%h: got %h want %h", ins[i], signals, exp[i]);
            end
        end
    endtask

    task automatic test_mem;
        apply(8'h80);
        tests++;
        if (signals !== 14'h0B80) begin
            fails++; $display("FAIL mem_lw: got %h want 0B80", signals);
        end
        apply(8'hB0);
        tests++;
        if (signals !== 14'h06B0) begin
            fails++; $display("FAIL mem_sw: got %h want 06B0", signals);
        end
    endtask

    task automatic test_branch_imm;
        logic [7:0]  ins [5] = '{8'h60, 8'h70, 8'hF0, 8'h12, 8'h15};
        logic [13:0] exp [5] = '{14'h1060, 14'h1070, 14'h00F0, 14'h0312, 14'h0315};
        for (int i = 0; i < 5; i++) begin
            apply(ins[i]);
            tests++;
            if (signals !== exp[i]) begin
                fails++; $display("FAIL branch_imm_%h: got %h want %h", ins[i], signals, exp[i]);
            end
        end
    endtask

    task automatic test_reserved;
        logic [3:0] ops [5] = '{4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
        logic [7:0] ins;
        for (int i = 0; i < 5; i++) begin
            ins = {ops[i], 4'h5};
            apply(ins);
            tests++;
            if (signals !== {6'b000000, ins}) begin
                fails++; $display("FAIL reserved_%h: got %h want %h", ins, signals, {6'b000000, ins});
            end
        end
    endtask

    task automatic test_hold;
        apply(8'h0D);
        @(negedge clk);
        instruction = 8'h80;
        #2;
        instruction = 8'hB0;
        #1;
        tests++;
        if (signals !== 14'h210D) begin
            fails++; $display("FAIL hold_mid_cycle: got %h want 210D", signals);
        end
        @(posedge clk); #1;
        tests++;
        if (signals !== 14'h06B0) begin
            fails++; $display("FAIL hold_next_edge: got %h want 06B0", signals);
        end
    endtask

    task automatic test_sweep;
        logic [13:0] exp;
        int bad_val, bad_excl;
        bad_val  = 0;
        bad_excl = 0;
        for (int i = 0; i < 256; i++) begin
            apply(8'(i));
            exp = ref_decode(8'(i));
            if (signals !== exp) begin
                bad_val++;
                if (bad_val <= 4)
                    $display("FAIL sweep_%h: got %h want %h", 8'(i), signals, exp);
            end
            if ((signals[11] && signals[10]) ||
                (signals[12] && (signals[8] || signals[10]))) begin
                bad_excl++;
                if (bad_excl <= 4)
                    $display("FAIL exclusion_%h: got %h want no conflicting bits", 8'(i), signals);
            end
        end
        tests++;
        if (bad_val != 0) begin
            fails++; $display("FAIL sweep_total: got %0d mismatching values want 0", bad_val);
        end
        tests++;
        if (bad_excl != 0) begin
            fails++; $display("FAIL exclusion_total: got %0d violations want 0", bad_excl);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_imm();
        test_reserved();
        test_hold();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
